// File: rtl/hub75_pkg.sv
// Shared HUB75 constants and types, used by both the driver and this receiver.
package hub75_pkg;

  localparam int HUB75_WIDTH  = 64;
  localparam int HUB75_ADDR_W = 5;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DRAIN_TOP = 2'd1,
    DRAIN_BOT = 2'd2
  } drain_state_t;

endpackage

// File: rtl/hub75_sync.sv
// N-stage synchronizer followed by an edge-history flop.
// q is the history flop, so a data vector synchronized here lines up with the
// registered rising-edge flag of a control pin synchronized by a twin instance.
module hub75_sync #(
  parameter int           W       = 1,
  parameter int           STAGES  = 2,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] stg_r [STAGES];
  logic [W-1:0] hist_r;
  logic [W-1:0] rise_r;

  // Metastability chain, edge history and registered rising-edge flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_r[i] <= RST_VAL;
      end
      hist_r <= RST_VAL;
      rise_r <= {W{1'b0}};
    end else begin
      stg_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stg_r[i] <= stg_r[i-1];
      end
      hist_r <= stg_r[STAGES-1];
      rise_r <= stg_r[STAGES-1] & ~hist_r;
    end
  end

  assign q    = hist_r;
  assign rise = rise_r;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 receiver: rebuilds latched rows from the panel pins and replays them
// as one pixel write per column, top half first, over a valid/ready stream.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int WIDTH       = HUB75_WIDTH,
  parameter int ADDR_W      = HUB75_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLK100MHZ,
  input  logic                     CPU_RESETN,
  input  logic                     hub_clk,
  input  logic                     hub_lat,
  input  logic                     hub_oe,
  input  logic [ADDR_W-1:0]        hub_addr,
  input  logic [2:0]               hub_rgb1,
  input  logic [2:0]               hub_rgb2,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [ADDR_W:0]          wr_row,
  output logic [$clog2(WIDTH)-1:0] wr_col,
  output logic [2:0]               wr_rgb,
  output logic                     frame_start,
  output logic                     oe_active,
  output logic                     len_err,
  output logic                     overrun,
  input  logic                     clr_err
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(2 * WIDTH);
  localparam int DW    = ADDR_W + 6;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_TOP  = DRAIN_TOP;
  localparam logic [1:0] ST_BOT  = DRAIN_BOT;

  logic              clk_rise_s, lat_rise_s, oe_q_s;
  logic              clk_lvl_unused_s, lat_lvl_unused_s, oe_rise_unused_s;
  logic [DW-1:0]     data_q_s, data_rise_unused_s;
  logic [ADDR_W-1:0] addr_s;
  rgb_t              rgb1_s, rgb2_s;

  rgb_t [WIDTH-1:0]  sr1_r, sr2_r, sr1_next_s, sr2_next_s;
  rgb_t [WIDTH-1:0]  buf1_r, buf2_r, buf1_next_s, buf2_next_s;
  logic [CNT_W-1:0]  bit_cnt_r, cnt_next_s;
  logic [1:0]        state_r, state_next_s;
  logic [COL_W-1:0]  col_r, col_next_s;
  logic [ADDR_W-1:0] addr_r, addr_next_s;
  logic              xfer_s, accept_s, drop_s, len_set_s;

  logic              wr_valid_r, frame_start_r, oe_active_r, len_err_r, overrun_r;
  logic [ADDR_W:0]   wr_row_r;
  logic [COL_W-1:0]  wr_col_r;
  rgb_t              wr_rgb_r;

  hub75_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .d(hub_clk), .q(clk_lvl_unused_s), .rise(clk_rise_s)
  );
  hub75_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lat (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .d(hub_lat), .q(lat_lvl_unused_s), .rise(lat_rise_s)
  );
  hub75_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_oe (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .d(hub_oe), .q(oe_q_s), .rise(oe_rise_unused_s)
  );
  hub75_sync #(.W(DW), .STAGES(SYNC_STAGES), .RST_VAL({DW{1'b0}})) u_sync_data (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .d({hub_addr, hub_rgb1, hub_rgb2}),
    .q(data_q_s), .rise(data_rise_unused_s)
  );

  assign addr_s = data_q_s[DW-1:6];
  assign rgb1_s = rgb_t'(data_q_s[5:3]);
  assign rgb2_s = rgb_t'(data_q_s[2:0]);
  assign xfer_s = wr_valid_r & wr_ready;

  // Post-shift view of the shift registers and bit counter (a latch sees this)
  always_comb begin
    sr1_next_s = sr1_r;
    sr2_next_s = sr2_r;
    cnt_next_s = bit_cnt_r;
    if (clk_rise_s) begin
      sr1_next_s = {sr1_r[WIDTH-2:0], rgb1_s};
      sr2_next_s = {sr2_r[WIDTH-2:0], rgb2_s};
      if (bit_cnt_r != CNT_MAX) begin
        cnt_next_s = bit_cnt_r + CNT_W'(1);
      end else begin
        cnt_next_s = bit_cnt_r;
      end
    end else begin
      cnt_next_s = bit_cnt_r;
    end
  end

  assign len_set_s = lat_rise_s && (cnt_next_s != CNT_FULL);

  // Drain sequencing: accept a latch only when idle, walk columns on handshake
  always_comb begin
    state_next_s = state_r;
    col_next_s   = col_r;
    addr_next_s  = addr_r;
    buf1_next_s  = buf1_r;
    buf2_next_s  = buf2_r;
    accept_s     = 1'b0;
    drop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (lat_rise_s) begin
          accept_s     = 1'b1;
          state_next_s = ST_TOP;
          col_next_s   = COL_ZERO;
          addr_next_s  = addr_s;
          buf1_next_s  = sr1_next_s;
          buf2_next_s  = sr2_next_s;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_TOP: begin
        drop_s = lat_rise_s;
        if (xfer_s) begin
          if (col_r == COL_LAST) begin
            state_next_s = ST_BOT;
            col_next_s   = COL_ZERO;
          end else begin
            col_next_s = col_r + COL_W'(1);
          end
        end else begin
          col_next_s = col_r;
        end
      end
      ST_BOT: begin
        drop_s = lat_rise_s;
        if (xfer_s) begin
          if (col_r == COL_LAST) begin
            state_next_s = ST_IDLE;
            col_next_s   = COL_ZERO;
          end else begin
            col_next_s = col_r + COL_W'(1);
          end
        end else begin
          col_next_s = col_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        col_next_s   = COL_ZERO;
      end
    endcase
  end

  // Shift registers, bit counter, row buffers and drain state
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sr1_r     <= '{default: 3'b000};
      sr2_r     <= '{default: 3'b000};
      buf1_r    <= '{default: 3'b000};
      buf2_r    <= '{default: 3'b000};
      bit_cnt_r <= {CNT_W{1'b0}};
      state_r   <= ST_IDLE;
      col_r     <= COL_ZERO;
      addr_r    <= {ADDR_W{1'b0}};
    end else begin
      sr1_r     <= sr1_next_s;
      sr2_r     <= sr2_next_s;
      buf1_r    <= buf1_next_s;
      buf2_r    <= buf2_next_s;
      bit_cnt_r <= lat_rise_s ? {CNT_W{1'b0}} : cnt_next_s;
      state_r   <= state_next_s;
      col_r     <= col_next_s;
      addr_r    <= addr_next_s;
    end
  end

  // Registered stream outputs, status pulses and sticky error flags
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      wr_valid_r    <= 1'b0;
      wr_row_r      <= {(ADDR_W + 1){1'b0}};
      wr_col_r      <= COL_ZERO;
      wr_rgb_r      <= 3'b000;
      frame_start_r <= 1'b0;
      oe_active_r   <= 1'b0;
      len_err_r     <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      wr_valid_r    <= (state_next_s != ST_IDLE);
      wr_row_r      <= {(state_next_s == ST_BOT), addr_next_s};
      wr_col_r      <= col_next_s;
      wr_rgb_r      <= (state_next_s == ST_BOT) ? buf2_next_s[col_next_s] : buf1_next_s[col_next_s];
      frame_start_r <= accept_s && (addr_s == {ADDR_W{1'b0}});
      oe_active_r   <= ~oe_q_s;
      len_err_r     <= len_set_s ? 1'b1 : (clr_err ? 1'b0 : len_err_r);
      overrun_r     <= drop_s ? 1'b1 : (clr_err ? 1'b0 : overrun_r);
    end
  end

  assign wr_valid    = wr_valid_r;
  assign wr_row      = wr_row_r;
  assign wr_col      = wr_col_r;
  assign wr_rgb      = wr_rgb_r;
  assign frame_start = frame_start_r;
  assign oe_active   = oe_active_r;
  assign len_err     = len_err_r;
  assign overrun     = overrun_r;

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Receive-side counterpart of the HUB75 matrix driver; behaves like a panel's shift-register/latch front end.
- Samples CLK/LAT/OE/address/RGB pins with CLK100MHZ and reconstructs each latched row.
- Emits one pixel-write per column per half-panel on a valid/ready stream for a frame buffer or scoreboard.
- Used for FPGA loopback self-test and as a panel emulator in simulation.

Parameters:
WIDTH, 64, columns per row (bits shifted per latch)
ADDR_W, 5, row-address width; half-panel height = 2**ADDR_W
SYNC_STAGES, 2, synchronizer flops on every HUB75 input (>=2)

Ports:
CLK100MHZ  in  1  system clock
CPU_RESETN  in  1  asynchronous active-low reset
hub_clk  in  1  HUB75 shift clock
hub_lat  in  1  HUB75 latch
hub_oe  in  1  HUB75 output enable, active-low
hub_addr  in  ADDR_W  row address A..E (A = bit 0)
hub_rgb1  in  3  {R1,G1,B1}, upper half
hub_rgb2  in  3  {R2,G2,B2}, lower half
wr_valid  out  1  pixel write valid
wr_ready  in  1  pixel write ready
wr_row  out  ADDR_W+1  panel row, 0..2**(ADDR_W+1)-1
wr_col  out  $clog2(WIDTH)  column
wr_rgb  out  3  {R,G,B}
frame_start  out  1  one-cycle pulse when a row with address 0 is accepted
oe_active  out  1  synchronized, inverted hub_oe (1 = panel lit)
len_err  out  1  sticky: latch seen after bit count != WIDTH
overrun  out  1  sticky: latch seen while still draining
clr_err  in  1  clears len_err and overrun

Behaviour:
- Reset: all outputs 0; state IDLE; shift registers, row buffers and bit counter 0; synchronizers 0 except hub_oe synchronizer, which resets to 1.
- Synchronization:
  - All hub_* inputs pass through SYNC_STAGES flops plus one edge-history flop.
  - Data and control share the same depth, so data stays aligned with the clock edge.
  - Senders must hold hub_clk high and low each >= SYNC_STAGES+1 system cycles, with data stable across the rising edge.
- Shift:
  - On each synchronized hub_clk rising edge: sr1 <= {sr1[WIDTH-2:0], rgb1}; same for sr2.
  - Bit index equals column: the last bit shifted is column 0, the first of WIDTH bits is column WIDTH-1.
  - Bit counter increments and saturates at 2*WIDTH-1.
- Latch: acted on at the synchronized hub_lat rising edge only.
  - In IDLE: row buffers <= shift registers, captured addr <= hub_addr, state -> DRAIN_TOP, counter <= 0.
  - Set len_err if counter != WIDTH.
  - frame_start pulses the same cycle if addr == 0.
  - In DRAIN_TOP/DRAIN_BOT: the latch is dropped (buffers unchanged), overrun set, counter <= 0.
- Latency: wr_valid rises the cycle after the latch event, which occurs SYNC_STAGES+1 cycles after the first system edge that samples hub_lat high.
- Drain FSM: IDLE -> DRAIN_TOP -> DRAIN_BOT -> IDLE.
  - DRAIN_TOP: wr_row = {0,addr}, wr_col 0..WIDTH-1, wr_rgb = rowbuf1 column.
  - DRAIN_BOT: wr_row = {1,addr} (addr + 2**ADDR_W), data from rowbuf2.
  - Column advances only on wr_valid && wr_ready.
  - After the column WIDTH-1 transfer: TOP -> BOT (col 0), BOT -> IDLE (wr_valid low next cycle).
- Handshake:
  - wr_row/wr_col/wr_rgb must not change while wr_valid && !wr_ready.
  - wr_valid must not drop before its transfer.
  - With wr_ready held high: 2*WIDTH consecutive transfers.
- Shifting continues during drain; shift registers are independent of row buffers.
- Simultaneous hub_clk and hub_lat edges in one cycle: the shift applies first, and the latch captures the post-shift value.
- A hub_lat edge in the same cycle as the final BOT transfer still counts as overrun (drop).
- clr_err and a new error in the same cycle: the error wins (flag stays 1).
- Reset asserted mid-drain: immediate return to reset state with no further writes; sticky flags cleared.
- oe_active is display status only and does not gate capture.

Decomposition:
- Package hub75_pkg: HUB75_WIDTH, HUB75_ADDR_W, rgb_t (3-bit struct R,G,B), drain_state_t enum {IDLE, DRAIN_TOP, DRAIN_BOT}. The driver shares these constants.
- Sub-module hub75_sync: parameterized N-stage synchronizer with rising-edge output, reset value set by a parameter. Instantiated for hub_clk, hub_lat, hub_oe; vector form for address/RGB.

Test Plan:
- Shift 64 bits with rgb1 = 3'b010 and rgb2 = 3'b010, then latch with addr = 5 and wr_ready = 1 -> 128 writes: rows 5 then 37, cols 0..63, rgb 010, len_err = 0.
- Shift a pattern where column c has rgb1 = c[2:0], latch addr = 0 -> frame_start is one pulse; write at col c has rgb = c[2:0]. Confirms the column/bit ordering.
- Shift 63 bits then latch -> len_err = 1 and the row is still drained. Pulse clr_err -> len_err = 0.
- Hold wr_ready low for 10 cycles mid-row at col 17 -> outputs frozen at row/col 17, no skipped or duplicated columns.
- Latch twice with wr_ready = 0 -> overrun = 1; the drained data comes from the first row only.
- Assert CPU_RESETN low during DRAIN_BOT col 30 -> wr_valid = 0 and flags 0 the same cycle; after release, a new row drains from col 0.
